// File: rtl/interleaver_commutator_if.sv
// Byte-source handshake and commutator select bus between the source, the
// commutator controller and the interleaver/deinterleaver datapath.
interface interleaver_commutator_if #(
   parameter int SEL_W = 4
);
   logic             enable;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic [7:0]       data_out;
   logic             shift_en;
   logic [SEL_W-1:0] select;
   logic [SEL_W-1:0] deint_select;
   logic             locked;
   logic             deint_out_valid;
   logic             sync_lost;

   modport master (
      output enable, in_valid, in_data,
      input  in_ready, data_out, shift_en, select, deint_select,
             locked, deint_out_valid, sync_lost
   );

   modport slave (
      input  enable, in_valid, in_data,
      output in_ready, data_out, shift_en, select, deint_select,
             locked, deint_out_valid, sync_lost
   );
endinterface

// File: rtl/interleaver_commutator_ctrl.sv
// Commutator sequencer for the convolutional interleaver/deinterleaver pair:
// aligns sync bytes to branch 0, monitors lock and tracks deinterleaver fill.
module interleaver_commutator_ctrl #(
   parameter int          BRANCHES    = 12,
   parameter int          DEPTH_M     = 17,
   parameter int          SEL_W       = 4,
   parameter logic [7:0]  SYNC_BYTE   = 8'h47,
   parameter int          SYNC_PERIOD = 204,
   parameter int          CH_LAT      = 1,
   parameter int          MISS_MAX    = 3
) (
   input logic                     clk,
   input logic                     reset,
   interleaver_commutator_if.slave bus
);
   localparam int FILL   = DEPTH_M * BRANCHES * (BRANCHES - 1);
   localparam int FILL_W = $clog2(FILL + 1);
   localparam int BC_W   = $clog2(SYNC_PERIOD);
   localparam int MC_W   = $clog2(MISS_MAX + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HUNT = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]                   state;
   logic [BC_W-1:0]              byte_cnt;
   logic [MC_W-1:0]              miss_cnt;
   logic [FILL_W-1:0]            fill_cnt;
   logic [7:0]                   data_q;
   logic                         shift_q;
   logic [SEL_W-1:0]             sel_q;
   logic [CH_LAT-1:0][SEL_W-1:0] dly_q;
   logic                         dov_q;
   logic                         lost_q;

   logic accept, is_sync, at_sync, miss_last;

   // Ready is gated by enable so a byte is never accepted on the edge that drops to IDLE.
   assign bus.in_ready = (state != S_IDLE) && bus.enable;
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_sync      = (bus.in_data == SYNC_BYTE);
   assign at_sync      = (byte_cnt == '0);
   assign miss_last    = at_sync && !is_sync && (miss_cnt == MC_W'(MISS_MAX - 1));

   assign bus.data_out        = data_q;
   assign bus.shift_en        = shift_q;
   assign bus.select          = sel_q;
   assign bus.deint_select    = dly_q[CH_LAT-1];
   assign bus.locked          = (state == S_RUN);
   assign bus.deint_out_valid = dov_q;
   assign bus.sync_lost       = lost_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         miss_cnt <= '0;
         fill_cnt <= '0;
         data_q   <= '0;
         shift_q  <= 1'b0;
         sel_q    <= '0;
         dly_q    <= '0;
         dov_q    <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         shift_q  <= 1'b0;
         lost_q   <= 1'b0;
         dly_q[0] <= sel_q;
         for (int i = 1; i < CH_LAT; i++) dly_q[i] <= dly_q[i-1];

         if (!bus.enable) begin
            state    <= S_IDLE;
            sel_q    <= '0;
            byte_cnt <= '0;
            miss_cnt <= '0;
            fill_cnt <= '0;
            dov_q    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: state <= S_HUNT;
               S_HUNT: begin
                  if (accept && is_sync) begin
                     state    <= S_RUN;
                     data_q   <= bus.in_data;
                     shift_q  <= 1'b1;
                     sel_q    <= '0;
                     byte_cnt <= BC_W'(1);
                     miss_cnt <= '0;
                     fill_cnt <= FILL_W'(1);
                  end
               end
               S_RUN: begin
                  if (accept && miss_last) begin
                     state    <= S_HUNT;
                     lost_q   <= 1'b1;
                     byte_cnt <= '0;
                     miss_cnt <= '0;
                     fill_cnt <= '0;
                     dov_q    <= 1'b0;
                  end else begin
                     // Fill flag trails the count by one edge.
                     if (fill_cnt == FILL_W'(FILL)) dov_q <= 1'b1;
                     if (accept) begin
                        data_q   <= bus.in_data;
                        shift_q  <= 1'b1;
                        sel_q    <= (sel_q == SEL_W'(BRANCHES - 1)) ? '0 : sel_q + 1'b1;
                        byte_cnt <= (byte_cnt == BC_W'(SYNC_PERIOD - 1)) ? '0 : byte_cnt + 1'b1;
                        if (at_sync) miss_cnt <= is_sync ? '0 : miss_cnt + 1'b1;
                        if (fill_cnt != FILL_W'(FILL)) fill_cnt <= fill_cnt + 1'b1;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
// Bench for interleaver_commutator_ctrl: packet-level reference model checked
// every cycle, plus directed literal checks at the key events.
module tb_interleaver_commutator_ctrl;
   localparam int B      = 12;
   localparam int PERIOD = 204;
   localparam int FILL   = 17 * 12 * 11;
   localparam int MMAX   = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   interleaver_commutator_if #(.SEL_W(4)) bus();

   interleaver_commutator_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   // Reference model: mode 0 idle, 1 hunting, 2 locked; pos is the byte's place in its packet.
   int m_mode, m_pos, m_miss, m_fwd, m_sel, m_dsel, m_data;
   bit m_shift, m_dov, m_lost;

   always @(posedge clk) begin
      bit acc;
      acc = bus.in_valid && bus.enable && (m_mode != 0);
      m_dsel  = m_sel;
      m_shift = 0;
      m_lost  = 0;
      if (reset) begin
         m_mode = 0; m_pos = 0; m_miss = 0; m_fwd = 0;
         m_sel = 0; m_dsel = 0; m_data = 0; m_dov = 0;
      end else if (!bus.enable) begin
         m_mode = 0; m_sel = 0; m_pos = 0; m_fwd = 0; m_miss = 0; m_dov = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (acc && bus.in_data == 8'h47) begin
            m_mode = 2; m_data = bus.in_data; m_shift = 1;
            m_sel = 0; m_pos = 1; m_miss = 0; m_fwd = 1;
         end
      end else begin
         if (acc && m_pos == 0 && bus.in_data != 8'h47 && m_miss + 1 == MMAX) begin
            m_mode = 1; m_lost = 1; m_pos = 0; m_miss = 0; m_fwd = 0; m_dov = 0;
         end else begin
            m_dov = m_dov || (m_fwd == FILL);
            if (acc) begin
               if (m_pos == 0) m_miss = (bus.in_data == 8'h47) ? 0 : m_miss + 1;
               m_data  = bus.in_data;
               m_shift = 1;
               m_sel   = m_pos % B;
               m_pos   = (m_pos + 1) % PERIOD;
               m_fwd   = (m_fwd < FILL) ? m_fwd + 1 : FILL;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("in_ready", bus.in_ready, (m_mode != 0) && bus.enable);
      check("locked", bus.locked, m_mode == 2);
      check("shift_en", bus.shift_en, m_shift);
      check("data_out", bus.data_out, m_data);
      check("select", bus.select, m_sel);
      check("deint_select", bus.deint_select, m_dsel);
      check("deint_out_valid", bus.deint_out_valid, m_dov);
      check("sync_lost", bus.sync_lost, m_lost);
   end

   int tpos = 0;
   int fwd_tb = 0;

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = d;
   endtask

   task automatic sample();
      @(posedge clk);
      #2;
   endtask

   task automatic pkt_byte(input bit corrupt);
      logic [7:0] d;
      d = (tpos == 0) ? (corrupt ? 8'h00 : 8'h47) : 8'(tpos);
      step(1'b1, d);
      tpos = (tpos + 1) % PERIOD;
      fwd_tb++;
   endtask

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_locked", bus.locked, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_select", bus.select, 0);
      check("rst_data", bus.data_out, 0);
      reset = 1'b0;
      bus.enable = 1'b1;

      // Hunt through a run of non-sync bytes, then lock.
      for (int i = 0; i <= 16; i++) step(1'b1, 8'(i));
      step(1'b1, 8'h47);
      sample();
      check("lock_data", bus.data_out, 8'h47);
      check("lock_select", bus.select, 0);
      check("lock_locked", bus.locked, 1);
      check("lock_shift", bus.shift_en, 1);
      tpos = 1; fwd_tb = 1;

      // Two more packets; second sync lands on branch 0.
      repeat (PERIOD - 1) pkt_byte(0);
      pkt_byte(0);
      sample();
      check("sync2_select", bus.select, 0);
      check("sync2_data", bus.data_out, 8'h47);
      repeat (PERIOD - 1) pkt_byte(0);

      // Gapped traffic.
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) pkt_byte(0);
         else begin
            step(1'b0, 8'hAA);
            if (i == 5) begin
               sample();
               check("gap_shift", bus.shift_en, 0);
            end
         end
      end

      // Fill the deinterleaver.
      while (fwd_tb < FILL - 1) pkt_byte(0);
      pkt_byte(0);
      sample();
      check("fill_last_dov", bus.deint_out_valid, 0);
      step(1'b0, 8'h00);
      sample();
      check("fill_dov", bus.deint_out_valid, 1);

      // Three corrupted syncs in a row.
      while (tpos != 0) pkt_byte(0);
      for (int k = 0; k < 3; k++) begin
         pkt_byte(1);
         sample();
         if (k == 0) begin
            check("miss1_locked", bus.locked, 1);
            check("miss1_shift", bus.shift_en, 1);
         end
         if (k == 2) begin
            check("miss3_lost", bus.sync_lost, 1);
            check("miss3_shift", bus.shift_en, 0);
            check("miss3_locked", bus.locked, 0);
            check("miss3_dov", bus.deint_out_valid, 0);
         end
         if (k < 2) while (tpos != 0) pkt_byte(0);
      end
      step(1'b1, 8'h12);
      step(1'b1, 8'h47);
      sample();
      check("relock_select", bus.select, 0);
      check("relock_locked", bus.locked, 1);
      tpos = 1; fwd_tb = 1;
      repeat (30) pkt_byte(0);

      // Drop enable with a byte pending.
      step(1'b1, 8'h05);
      bus.enable = 1'b0;
      sample();
      check("dis_locked", bus.locked, 0);
      check("dis_select", bus.select, 0);
      check("dis_shift", bus.shift_en, 0);
      @(negedge clk);
      bus.enable = 1'b1;
      repeat (3) step(1'b1, 8'h47);
      tpos = 1;
      repeat (20) pkt_byte(0);

      // Reset mid-stream with a stale valid.
      step(1'b1, 8'h33);
      reset = 1'b1;
      sample();
      check("mid_rst_locked", bus.locked, 0);
      check("mid_rst_shift", bus.shift_en, 0);
      check("mid_rst_data", bus.data_out, 0);
      check("mid_rst_select", bus.select, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
